dbg_uart_sched: RTL and testbench

DBG_UART_SCHED -- requirements
Module: dbg_uart_sched

---
 rtl/dbg_uart_sched_pkg.sv | 28 ++
 rtl/dbg_uart_sched_if.sv | 9 +
 rtl/dbg_uart_sched_trig_sync.sv | 22 ++
 rtl/dbg_uart_sched.sv | 109 ++++++++++
 tb/tb_dbg_uart_sched.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dbg_uart_sched_pkg.sv
// Shared constants and state encoding for the debug-snapshot UART scheduler.
package dbg_uart_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT_ACK, ST_WAIT_DONE} state_t;
    typedef logic [3:0] idx_t;

    localparam int         FRAME_LEN       = 15;
    localparam int         SHADOW_LEN      = FRAME_LEN - 1;
    localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
    localparam int         ACK_TIMEOUT_DEF = 4;

    // Byte positions within a frame; the shadow register holds indices 1..14.
    localparam idx_t IDX_SYNC   = 4'd0;
    localparam idx_t IDX_STATUS = 4'd1;
    localparam idx_t IDX_PC_HI  = 4'd2;
    localparam idx_t IDX_PC_LO  = 4'd3;
    localparam idx_t IDX_SP_HI  = 4'd4;
    localparam idx_t IDX_SP_LO  = 4'd5;
    localparam idx_t IDX_AF_HI  = 4'd6;
    localparam idx_t IDX_AF_LO  = 4'd7;
    localparam idx_t IDX_BC_HI  = 4'd8;
    localparam idx_t IDX_BC_LO  = 4'd9;
    localparam idx_t IDX_DE_HI  = 4'd10;
    localparam idx_t IDX_DE_LO  = 4'd11;
    localparam idx_t IDX_HL_HI  = 4'd12;
    localparam idx_t IDX_HL_LO  = 4'd13;
    localparam idx_t IDX_OPCODE = 4'd14;
    localparam idx_t IDX_LAST   = IDX_OPCODE;
endpackage

// File: rtl/dbg_uart_sched_if.sv
// Byte-level handshake between the frame scheduler and a UART transmitter.
interface dbg_uart_sched_if;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_busy;

    modport master (output tx_start, output tx_byte, input tx_busy);
    modport slave  (input tx_start, input tx_byte, output tx_busy);
endinterface

// File: rtl/dbg_uart_sched_trig_sync.sv
// Two-flop synchronizer for the core-domain trigger plus rising-edge detect.
module trig_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic trigger,
    output logic pulse
);
    logic [1:0] sync;
    logic       prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[0], trigger};
            prev <= sync[1];
        end
    end

    assign pulse = sync[1] & ~prev;
endmodule

// File: rtl/dbg_uart_sched.sv
// Captures a CPU register snapshot on trigger and streams it as a 15-byte
// frame to a UART, one byte per tx_start/tx_busy handshake.
module dbg_uart_sched
    import dbg_uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                trigger,
    input  logic                enable,
    input  logic [7:0]          dbg_status,
    input  logic [15:0]         dbg_pc,
    input  logic [15:0]         dbg_sp,
    input  logic [15:0]         dbg_af,
    input  logic [15:0]         dbg_bc,
    input  logic [15:0]         dbg_de,
    input  logic [15:0]         dbg_hl,
    input  logic [7:0]          dbg_opcode,
    dbg_uart_sched_if.master    uart,
    output logic                busy,
    output logic [7:0]          drop_cnt
);
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

    state_t                         state;
    idx_t                           idx;
    logic [SHADOW_LEN-1:0][7:0]     shadow;
    logic [7:0]                     tx_byte_q;
    logic [ACK_W-1:0]               ack_cnt;
    logic                           trig_pulse;
    logic                           accept;
    logic [7:0]                     next_byte;

    trig_sync u_trig_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .trigger (trigger),
        .pulse   (trig_pulse)
    );

    assign accept = trig_pulse && (state == ST_IDLE) && enable;
    // Frame byte idx+1 lives at shadow[idx] because byte 0 is the sync marker.
    assign next_byte = (idx < IDX_LAST) ? shadow[idx] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= IDX_SYNC;
            shadow    <= '0;
            tx_byte_q <= 8'h00;
            ack_cnt   <= '0;
            busy      <= 1'b0;
            drop_cnt  <= 8'h00;
        end else begin
            if (trig_pulse && !accept && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shadow    <= {dbg_opcode,
                                      dbg_hl[7:0], dbg_hl[15:8],
                                      dbg_de[7:0], dbg_de[15:8],
                                      dbg_bc[7:0], dbg_bc[15:8],
                                      dbg_af[7:0], dbg_af[15:8],
                                      dbg_sp[7:0], dbg_sp[15:8],
                                      dbg_pc[7:0], dbg_pc[15:8],
                                      dbg_status};
                        idx       <= IDX_SYNC;
                        tx_byte_q <= SYNC_BYTE;
                        busy      <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!uart.tx_busy) begin
                        ack_cnt <= '0;
                        state   <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    // A UART that never raises tx_busy still gets the frame moving.
                    if (uart.tx_busy || ack_cnt == ACK_W'(ACK_TIMEOUT - 1))
                        state <= ST_WAIT_DONE;
                    else
                        ack_cnt <= ack_cnt + 1'b1;
                end
                ST_WAIT_DONE: begin
                    if (!uart.tx_busy) begin
                        if (idx == IDX_LAST) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            idx       <= idx + 4'd1;
                            tx_byte_q <= next_byte;
                            state     <= ST_LOAD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign uart.tx_start = (state == ST_LOAD) && !uart.tx_busy;
    assign uart.tx_byte  = tx_byte_q;
endmodule

// File: tb/tb_dbg_uart_sched.sv
// Randomized bench for dbg_uart_sched with a protocol-level frame/drop model.
module tb_dbg_uart_sched;
    import dbg_uart_pkg::*;

    localparam int TB_ACK = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trigger = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  dbg_status = 8'h00, dbg_opcode = 8'h00;
    logic [15:0] dbg_pc = 16'h0, dbg_sp = 16'h0, dbg_af = 16'h0;
    logic [15:0] dbg_bc = 16'h0, dbg_de = 16'h0, dbg_hl = 16'h0;
    logic        busy;
    logic [7:0]  drop_cnt;

    dbg_uart_sched_if uif ();

    dbg_uart_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trigger    (trigger),
        .enable     (enable),
        .dbg_status (dbg_status),
        .dbg_pc     (dbg_pc),
        .dbg_sp     (dbg_sp),
        .dbg_af     (dbg_af),
        .dbg_bc     (dbg_bc),
        .dbg_de     (dbg_de),
        .dbg_hl     (dbg_hl),
        .dbg_opcode (dbg_opcode),
        .uart       (uif),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // UART stand-in: busy for uart_len cycles after each start, or never when dead.
    int uart_len = 10;
    bit uart_dead = 1'b0;
    int ucnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uif.tx_busy <= 1'b0;
            ucnt        <= 0;
        end else if (uart_dead) begin
            uif.tx_busy <= 1'b0;
        end else if (uif.tx_start) begin
            uif.tx_busy <= 1'b1;
            ucnt        <= uart_len - 1;
        end else if (ucnt > 0) begin
            ucnt <= ucnt - 1;
        end else begin
            uif.tx_busy <= 1'b0;
        end
    end

    // Reference model: frame in progress, bytes still owed, drops seen.
    typedef enum {M_IDLE, M_ACTIVE, M_TAIL} mst_t;
    mst_t       mst = M_IDLE;
    logic [7:0] exp_q[$];
    logic [7:0] cap[$];
    logic [7:0] last_sent = 8'h00;
    logic [2:0] hist = 3'b000;
    int         cyc = 0, acc_cyc = 0, last_start_cyc = 0;
    int         n_start = 0, sent = 0, low_run = 0, m_drops = 0;
    bit         first_pending = 1'b0, prev_start = 1'b0;

    always @(negedge clk) begin
        logic det;
        cyc++;
        if (!rst_n) begin
            mst = M_IDLE; exp_q.delete(); hist = 3'b000; m_drops = 0;
            prev_start = 1'b0; first_pending = 1'b0; last_sent = 8'h00; sent = 0;
        end else begin
            chk("drop_cnt", drop_cnt, m_drops[7:0]);
            if (mst == M_ACTIVE) chk("busy_in_frame", busy, 1);
            else if (mst == M_IDLE) chk("busy_idle", busy, 0);

            if (uif.tx_start) begin
                n_start++;
                chk("start_back_to_back", prev_start, 0);
                chk("start_in_frame", (mst == M_ACTIVE) && (exp_q.size() > 0), 1);
                if (mst == M_ACTIVE && exp_q.size() > 0) begin
                    chk("tx_byte", uif.tx_byte, exp_q[0]);
                    if (first_pending) chk("first_latency", cyc - acc_cyc, 1);
                    if (uart_dead && sent > 0) chk("dead_gap", cyc - last_start_cyc, TB_ACK + 2);
                    first_pending = 1'b0;
                    last_start_cyc = cyc;
                    cap.push_back(uif.tx_byte);
                    last_sent = exp_q.pop_front();
                    sent++;
                    if (exp_q.size() == 0) begin
                        mst = M_TAIL;
                        low_run = 0;
                    end
                end
            end else if (uif.tx_busy && mst != M_IDLE) begin
                chk("tx_byte_hold", uif.tx_byte, last_sent);
            end
            prev_start = uif.tx_start;

            if (mst == M_TAIL) begin
                low_run = uif.tx_busy ? 0 : low_run + 1;
                if (low_run >= 7) mst = M_IDLE;
            end

            // Edge acted on at the coming posedge: sampled high two edges ago, low three ago.
            det  = hist[1] && !hist[2];
            hist = {hist[1:0], trigger};
            if (det) begin
                if (mst == M_IDLE && enable) begin
                    exp_q.delete();
                    exp_q.push_back(8'hA5);       exp_q.push_back(dbg_status);
                    exp_q.push_back(dbg_pc[15:8]); exp_q.push_back(dbg_pc[7:0]);
                    exp_q.push_back(dbg_sp[15:8]); exp_q.push_back(dbg_sp[7:0]);
                    exp_q.push_back(dbg_af[15:8]); exp_q.push_back(dbg_af[7:0]);
                    exp_q.push_back(dbg_bc[15:8]); exp_q.push_back(dbg_bc[7:0]);
                    exp_q.push_back(dbg_de[15:8]); exp_q.push_back(dbg_de[7:0]);
                    exp_q.push_back(dbg_hl[15:8]); exp_q.push_back(dbg_hl[7:0]);
                    exp_q.push_back(dbg_opcode);
                    mst = M_ACTIVE; acc_cyc = cyc; first_pending = 1'b1; sent = 0;
                end else if (m_drops < 255) begin
                    m_drops++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi = 3, input int lo = 3);
        trigger = 1'b1; tick(hi);
        trigger = 1'b0; tick(lo);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (mst != M_IDLE && k < 4000) begin tick(1); k++; end
        if (k >= 4000) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle: frame still open after %0d cycles, expected idle", k);
        end
        tick(3);
    endtask

    task automatic wait_sent(input int n);
        int k = 0;
        while (sent < n && k < 4000) begin tick(1); k++; end
        if (k >= 4000) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_sent: %0d bytes sent, expected %0d", sent, n);
        end
    endtask

    logic [7:0] golden [15] = '{8'hA5, 8'h41, 8'h01, 8'h50, 8'hFF, 8'hFE, 8'h01, 8'hB0,
                                 8'h00, 8'h13, 8'h00, 8'hD8, 8'h01, 8'h4D, 8'hC3};

    task automatic check_golden(input string name);
        chk({name, "_len"}, cap.size(), 15);
        for (int i = 0; i < 15 && i < cap.size(); i++) chk(name, cap[i], golden[i]);
    endtask

    task automatic set_golden_regs();
        dbg_pc = 16'h0150; dbg_sp = 16'hFFFE; dbg_af = 16'h01B0; dbg_bc = 16'h0013;
        dbg_de = 16'h00D8; dbg_hl = 16'h014D; dbg_status = 8'h41; dbg_opcode = 8'hC3;
    endtask

    initial begin
        int s0;
        tick(3);
        chk("rst_tx_start", uif.tx_start, 0);
        chk("rst_tx_byte", uif.tx_byte, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        tick(2);

        // Reference frame through a 10-cycle UART
        set_golden_regs();
        enable = 1'b1;
        cap.delete(); pulse(); wait_idle();
        check_golden("frame_ref");
        chk("busy_after_frame", busy, 0);

        // Snapshot isolation: pc changes right after latch
        cap.delete(); pulse();
        dbg_pc = 16'h1234;
        wait_idle();
        chk("snap_pc_hi", cap.size() > 3 ? cap[2] : 8'hxx, 8'h01);
        chk("snap_pc_lo", cap.size() > 3 ? cap[3] : 8'hxx, 8'h50);
        dbg_pc = 16'h0150;

        // Three triggers mid-frame, then a fresh one once idle
        cap.delete(); pulse(); wait_sent(2);
        repeat (3) pulse(2, 2);
        wait_idle();
        chk("drops_mid_frame", drop_cnt, 3);
        check_golden("frame_with_drops");
        cap.delete(); pulse(); wait_idle();
        chk("accept_after_idle", cap.size(), 15);
        chk("drops_unchanged", drop_cnt, 3);

        // Edge landing on the very cycle the frame returns to idle
        cap.delete(); pulse(); wait_sent(15);
        tick(uart_len - 2);
        trigger = 1'b1; tick(3); trigger = 1'b0; tick(3);
        wait_idle();
        chk("drop_on_return", drop_cnt, 4);
        chk("no_frame_on_return", busy, 0);

        // Saturation with enable low
        enable = 1'b0;
        s0 = n_start;
        repeat (300) pulse(2, 2);
        chk("drop_saturated", drop_cnt, 8'hFF);
        chk("no_start_disabled", n_start - s0, 0);
        enable = 1'b1;

        // Reset during byte 7
        cap.delete(); pulse(); wait_sent(8); tick(3);
        rst_n = 1'b0; #1;
        chk("midrst_tx_start", uif.tx_start, 0);
        chk("midrst_tx_byte", uif.tx_byte, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_drop_cnt", drop_cnt, 0);
        tick(2); rst_n = 1'b1;
        s0 = n_start; tick(40);
        chk("no_start_after_rst", n_start - s0, 0);

        // Dead UART: every byte advances on the ack timeout
        uart_dead = 1'b1;
        cap.delete(); s0 = n_start; pulse(); wait_idle();
        chk("dead_start_count", n_start - s0, 15);
        check_golden("frame_dead");
        uart_dead = 1'b0;

        // Randomized frames, enables, UART speeds and mid-frame triggers
        for (int r = 0; r < 10; r++) begin
            dbg_status = 8'($urandom); dbg_opcode = 8'($urandom);
            dbg_pc = 16'($urandom); dbg_sp = 16'($urandom); dbg_af = 16'($urandom);
            dbg_bc = 16'($urandom); dbg_de = 16'($urandom); dbg_hl = 16'($urandom);
            uart_len  = int'($urandom_range(3, 12));
            uart_dead = ($urandom_range(0, 3) == 0);
            enable    = ($urandom_range(0, 4) != 0);
            cap.delete(); pulse();
            if (mst != M_IDLE) begin
                repeat ($urandom_range(0, 3)) begin
                    tick(int'($urandom_range(0, 5)));
                    if (exp_q.size() >= 3) begin
                        enable = 1'($urandom);
                        dbg_pc = 16'($urandom);
                        pulse(2, 2);
                    end
                end
            end
            wait_idle();
            tick(int'($urandom_range(0, 6)));
            enable = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
